// File: rtl/seg_scan_ctrl_if.sv
// Signal bundle between the BCD source and the seven-segment scan controller.
// The master drives digits and controls; the slave (scan controller) drives the display lines.
interface seg_scan_ctrl_if;
    logic       seg_en;
    logic [3:0] unit;
    logic [3:0] ten;
    logic [3:0] hun;
    logic [3:0] tho;
    logic [3:0] t_tho;
    logic [3:0] h_hun;
    logic [5:0] point;
    logic       sign;
    logic [5:0] sel;
    logic [7:0] seg;
    logic       frame_start;

    modport master (
        output seg_en, unit, ten, hun, tho, t_tho, h_hun, point, sign,
        input  sel, seg, frame_start
    );

    modport slave (
        input  seg_en, unit, ten, hun, tho, t_tho, h_hun, point, sign,
        output sel, seg, frame_start
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Six-digit common-anode seven-segment scan controller with a per-frame input snapshot.
// Define SEG_LZB_EN to enable leading-zero blanking with a floating minus sign.
module seg_scan_ctrl #(
    parameter logic [15:0] CNT_MAX = 16'd49_999
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    seg_scan_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        SCAN  = 2'd2
    } state_e;

    state_e          state_q;
    logic [15:0]     cnt_q;
    logic [2:0]      idx_q;
    logic [5:0][3:0] digit_q;
    logic [5:0]      point_q;
    logic            sign_q;
    logic [5:0]      sel_q;
    logic [7:0]      seg_q;
    logic            fs_q;

    logic [5:0][3:0] digit_in;
    logic [7:0]      seg_d;

    assign digit_in = {bus.h_hun, bus.t_tho, bus.tho, bus.hun, bus.ten, bus.unit};

`ifdef SEG_LZB_EN
    logic [2:0] top_q;
    logic [2:0] top_d;

    // Highest digit that must stay visible: non-zero value or a lit decimal point.
    always_comb begin
        top_d = 3'd0;
        for (int i = 1; i < 6; i++) begin
            if (digit_in[i] != 4'd0 || bus.point[i]) top_d = 3'(i);
        end
    end
`endif

    function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    always_comb begin
        // NOTE: seg_d gets its value first, so no path through this block leaves it unassigned.
        seg_d = bcd_to_seg(digit_q[idx_q]);
`ifdef SEG_LZB_EN
        if (idx_q > top_q) seg_d = 8'hFF;
        if (sign_q && top_q != 3'd5 && idx_q == top_q + 3'd1) seg_d = 8'hBF;
`else
        if (sign_q && idx_q == 3'd5) seg_d = 8'hBF;
`endif
        if (point_q[idx_q]) seg_d[7] = 1'b0;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            // NOTE: the snapshot is cleared along with the control state so nothing stale survives reset.
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            digit_q <= '0;
            point_q <= '0;
            sign_q  <= 1'b0;
`ifdef SEG_LZB_EN
            top_q   <= '0;
`endif
            sel_q   <= '0;
            seg_q   <= 8'hFF;
            fs_q    <= 1'b0;
        end else begin
            sel_q <= '0;
            seg_q <= 8'hFF;
            fs_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    if (bus.seg_en) state_q <= LATCH;
                end
                LATCH: begin
                    digit_q <= digit_in;
                    point_q <= bus.point;
                    sign_q  <= bus.sign;
`ifdef SEG_LZB_EN
                    top_q   <= top_d;
`endif
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    state_q <= SCAN;
                    fs_q    <= 1'b1;
                end
                SCAN: begin
                    sel_q <= 6'b000001 << idx_q;
                    seg_q <= seg_d;
                    if (cnt_q == CNT_MAX) begin
                        cnt_q <= '0;
                        if (idx_q == 3'd5) state_q <= LATCH;
                        else               idx_q   <= idx_q + 3'd1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Disabling wins over every other transition.
            if (!bus.seg_en) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                idx_q   <= '0;
            end
        end
    end

    assign bus.sel         = sel_q;
    assign bus.seg         = seg_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with CNT_MAX=9; expected frames come from a digit-level model.
// Works in both builds: the model follows SEG_LZB_EN the same way the design does.
module tb_seg_scan_ctrl;

    localparam int DWELL = 10;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] enc_tbl [10];

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(.CNT_MAX(16'd9)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic step();
        @(negedge sys_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [5:0] e_sel, input logic [7:0] e_seg,
                           input logic e_fs);
        chk({tag, " sel"}, 32'(bus.sel), 32'(e_sel));
        chk({tag, " seg"}, 32'(bus.seg), 32'(e_seg));
        chk({tag, " frame_start"}, 32'(bus.frame_start), 32'(e_fs));
    endtask

    task automatic apply(input logic [5:0][3:0] dg, input logic [5:0] pt, input logic sg);
        bus.unit  = dg[0];
        bus.ten   = dg[1];
        bus.hun   = dg[2];
        bus.tho   = dg[3];
        bus.t_tho = dg[4];
        bus.h_hun = dg[5];
        bus.point = pt;
        bus.sign  = sg;
    endtask

    // What the six digits should look like, derived straight from the display rules.
    function automatic logic [5:0][7:0] model_frame(input logic [5:0][3:0] dg,
                                                    input logic [5:0] pt, input logic sg);
        logic [5:0][7:0] r;
        int top;
`ifdef SEG_LZB_EN
        top = 0;
        for (int i = 0; i < 6; i++) if (dg[i] != 0 || pt[i]) top = i;
`else
        top = 5;
`endif
        for (int i = 0; i < 6; i++) begin
            if (i > top)       r[i] = 8'hFF;
            else if (dg[i] < 10) r[i] = enc_tbl[dg[i]];
            else               r[i] = 8'hFF;
        end
`ifdef SEG_LZB_EN
        if (sg && top < 5) r[top+1] = 8'hBF;
`else
        if (sg) r[5] = 8'hBF;
`endif
        for (int i = 0; i < 6; i++) if (pt[i]) r[i][7] = 1'b0;
        return r;
    endfunction

    task automatic wait_frame();
        for (int i = 0; i < 200; i++) begin
            step();
            if (bus.frame_start === 1'b1) break;
        end
        chk("frame_start seen", 32'(bus.frame_start), 32'd1);
    endtask

    // Called on the cycle frame_start is visible; ends on the next frame_start cycle.
    task automatic check_frame(input string tag, input logic [5:0][7:0] exp, input int chg_at,
                               input logic [5:0][3:0] nd, input logic [5:0] np, input logic ns);
        int k = 0;
        for (int d = 0; d < 6; d++) begin
            for (int c = 0; c < DWELL; c++) begin
                step();
                k++;
                if (k == chg_at) apply(nd, np, ns);
                chk_out($sformatf("%s d%0d c%0d", tag, d, c), 6'b000001 << d, exp[d], 1'b0);
            end
        end
        step();
        chk_out({tag, " gap"}, 6'd0, 8'hFF, 1'b1);
    endtask

    initial begin
        logic [5:0][3:0] dg;
        logic [5:0][3:0] dg2;
        logic [5:0]      pt;
        logic            sg;
        logic [5:0][7:0] ex;

        enc_tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

        sys_rst_n  = 1'b0;
        bus.seg_en = 1'b1;
        dg = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        apply(dg, 6'd0, 1'b0);
        repeat (3) begin
            step();
            chk_out("reset", 6'd0, 8'hFF, 1'b0);
        end
        sys_rst_n = 1'b1;
        step();
        chk_out("after edge1", 6'd0, 8'hFF, 1'b0);
        step();
        chk_out("after edge2", 6'd0, 8'hFF, 1'b1);
        check_frame("full", {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82}, 0, dg, 6'd0, 1'b0);
        check_frame("full2", {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82}, 0, dg, 6'd0, 1'b0);

        // Value 42 with a minus sign.
        dg = {4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd2};
        apply(dg, 6'd0, 1'b1);
        wait_frame();
`ifdef SEG_LZB_EN
        ex = {8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'h99, 8'hA4};
`else
        ex = {8'hBF, 8'hC0, 8'hC0, 8'hC0, 8'h99, 8'hA4};
`endif
        check_frame("v42neg", ex, 0, dg, 6'd0, 1'b1);

        // Value 5 with the dp of digit 2 lit.
        dg = {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5};
        apply(dg, 6'b000100, 1'b0);
        wait_frame();
`ifdef SEG_LZB_EN
        ex = {8'hFF, 8'hFF, 8'hFF, 8'h40, 8'hC0, 8'h92};
`else
        ex = {8'hC0, 8'hC0, 8'hC0, 8'h40, 8'hC0, 8'h92};
`endif
        check_frame("v5dp", ex, 0, dg, 6'b000100, 1'b0);

        // Inputs changed while digit 2 is shown must wait for the next frame.
        dg  = {4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
        dg2 = {4'd0, 4'd0, 4'd3, 4'd1, 4'd0, 4'd9};
        apply(dg, 6'b100001, 1'b0);
        wait_frame();
        check_frame("snap_old", model_frame(dg, 6'b100001, 1'b0), 25, dg2, 6'b000010, 1'b1);
        check_frame("snap_new", model_frame(dg2, 6'b000010, 1'b1), 0, dg2, 6'b000010, 1'b1);

        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 6; i++)
                dg[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            pt = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
            sg = 1'($urandom_range(0, 1));
            apply(dg, pt, sg);
            wait_frame();
            check_frame($sformatf("rand%0d", n), model_frame(dg, pt, sg), 0, dg, pt, sg);
        end

        // Drop seg_en in the middle of digit 3, then re-enable.
        dg = {4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        apply(dg, 6'b001000, 1'b1);
        wait_frame();
        repeat (35) step();
        bus.seg_en = 1'b0;
        step();
        repeat (5) begin
            step();
            chk_out("disabled", 6'd0, 8'hFF, 1'b0);
        end
        bus.seg_en = 1'b1;
        step();
        chk_out("reen edge1", 6'd0, 8'hFF, 1'b0);
        step();
        chk_out("reen edge2", 6'd0, 8'hFF, 1'b1);
        check_frame("reen", model_frame(dg, 6'b001000, 1'b1), 0, dg, 6'b001000, 1'b1);

        // Reset in the middle of a scan blanks at that edge.
        repeat (25) step();
        sys_rst_n = 1'b0;
        repeat (2) begin
            step();
            chk_out("mid reset", 6'd0, 8'hFF, 1'b0);
        end
        sys_rst_n = 1'b1;
        step();
        chk_out("post reset edge1", 6'd0, 8'hFF, 1'b0);
        step();
        chk_out("post reset edge2", 6'd0, 8'hFF, 1'b1);
        check_frame("post reset", model_frame(dg, 6'b001000, 1'b1), 0, dg, 6'b001000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
